fwd_scoreboard: RTL and testbench

Parametrised bypass and hazard block for the WISC pipeline. It sits between decode and execute and keeps its own shift-register scoreboard of in-flight register writers, so pipeline stages no longer have to supply opcodes. Each cycle it resolves every decode source operand to the youngest matching in-flight result, and it raises a load-use stall when that result cannot be forwarded yet.

---
 rtl/fwd_pkg.sv | 19 +
 rtl/fwd_match_sel.sv | 34 +++
 rtl/fwd_scoreboard.sv | 115 +++++++++++
 tb/tb_fwd_scoreboard.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
package fwd_pkg;

  localparam int unsigned DEF_DATA_W    = 16;
  localparam int unsigned DEF_REG_AW    = 3;
  localparam int unsigned DEF_STAGES    = 3;
  localparam int unsigned DEF_SRC_PORTS = 3;

  localparam int unsigned STAGE_EX  = 0;
  localparam int unsigned STAGE_MEM = 1;

  // One in-flight register writer; dst width follows DEF_REG_AW.
  typedef struct packed {
    logic                  valid;
    logic [DEF_REG_AW-1:0] dst;
    logic                  load;
  } sb_entry_t;

endpackage

// File: rtl/fwd_match_sel.sv
// Youngest-first priority match of one source operand over the scoreboard.
module fwd_match_sel
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW,
  parameter int unsigned STAGES = DEF_STAGES,
  parameter int unsigned IDX_W  = $clog2(STAGES)
) (
  input  logic                     en_i,
  input  logic [REG_AW-1:0]        src_reg_i,
  input  logic [DATA_W-1:0]        src_data_i,
  input  sb_entry_t [STAGES-1:0]   sb_i,
  input  logic [STAGES*DATA_W-1:0] stage_data_i,
  output logic                     hit_o,
  output logic [IDX_W-1:0]         idx_o,
  output logic [DATA_W-1:0]        data_o
);

  // Scan oldest to youngest so the youngest match overwrites any older one.
  always_comb begin
    hit_o  = 1'b0;
    idx_o  = '0;
    data_o = src_data_i;
    for (int i = STAGES - 1; i >= 0; i--) begin
      if (en_i && sb_i[i].valid && (sb_i[i].dst == src_reg_i)) begin
        hit_o  = 1'b1;
        idx_o  = IDX_W'(i);
        data_o = stage_data_i[i*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Bypass/hazard block: shift-register scoreboard of in-flight writers,
// per-port youngest-first operand forwarding and load-use stall.
// Optional macro FWD_STALL_STATS_EN adds a saturating stall_count output.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned DATA_W    = DEF_DATA_W,
  parameter int unsigned REG_AW    = DEF_REG_AW,
  parameter int unsigned STAGES    = DEF_STAGES,
  parameter int unsigned SRC_PORTS = DEF_SRC_PORTS
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        issue_valid,
  input  logic                        issue_wr,
  input  logic [REG_AW-1:0]           issue_dst,
  input  logic                        issue_load,
  input  logic [SRC_PORTS-1:0]        src_valid,
  input  logic [SRC_PORTS*REG_AW-1:0] src_reg,
  input  logic [SRC_PORTS*DATA_W-1:0] src_data,
  input  logic [STAGES*DATA_W-1:0]    stage_data,
  input  logic                        pipe_hold,
  input  logic                        flush,
  output logic [SRC_PORTS*DATA_W-1:0] fwd_data,
  output logic [SRC_PORTS-1:0]        fwd_hit,
  output logic                        stall
`ifdef FWD_STALL_STATS_EN
  ,
  output logic [15:0]                 stall_count
`endif
);

  localparam int unsigned IDX_W = $clog2(STAGES);

  sb_entry_t [STAGES-1:0] sb_q, sb_d;
  logic      [IDX_W-1:0]  port_idx [SRC_PORTS];

  // Per-port priority match and operand mux.
  for (genvar p = 0; p < SRC_PORTS; p++) begin : g_port
    fwd_match_sel #(
      .DATA_W (DATA_W),
      .REG_AW (REG_AW),
      .STAGES (STAGES),
      .IDX_W  (IDX_W)
    ) u_sel (
      .en_i         (src_valid[p] & issue_valid),
      .src_reg_i    (src_reg[p*REG_AW +: REG_AW]),
      .src_data_i   (src_data[p*DATA_W +: DATA_W]),
      .sb_i         (sb_q),
      .stage_data_i (stage_data),
      .hit_o        (fwd_hit[p]),
      .idx_o        (port_idx[p]),
      .data_o       (fwd_data[p*DATA_W +: DATA_W])
    );
  end

  // Load-use: a winning match on a load still in EX cannot be forwarded yet.
  always_comb begin
    stall = 1'b0;
    for (int p = 0; p < SRC_PORTS; p++) begin
      if (fwd_hit[p] && (port_idx[p] == IDX_W'(STAGE_EX)) && sb_q[STAGE_EX].load) begin
        stall = 1'b1;
      end
    end
  end

  // Scoreboard shift; a stalled or flushed decode instruction becomes a bubble.
  always_comb begin
    sb_d = sb_q;
    if (!pipe_hold) begin
      for (int i = STAGES - 1; i > 0; i--) begin
        sb_d[i] = sb_q[i-1];
      end
      sb_d[0] = '0;
      if (issue_valid && issue_wr && !stall && !flush) begin
        sb_d[0].valid = 1'b1;
        sb_d[0].dst   = issue_dst;
        sb_d[0].load  = issue_load;
      end
    end
  end

  // Scoreboard state; reset drops all in-flight tracking at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sb_q <= '0;
    end else begin
      sb_q <= sb_d;
    end
  end

`ifdef FWD_STALL_STATS_EN
  logic [15:0] stall_count_q, stall_count_d;

  // Count stall cycles that actually held decode back, saturating.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !pipe_hold && !flush && (stall_count_q != 16'hFFFF)) begin
      stall_count_d = stall_count_q + 16'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`endif

endmodule

// File: tb/tb_fwd_scoreboard.sv
// Self-checking bench for fwd_scoreboard: directed scenarios plus random
// traffic against a history-queue reference model.
module tb_fwd_scoreboard;

  localparam int unsigned DATA_W    = 16;
  localparam int unsigned REG_AW    = 3;
  localparam int unsigned STAGES    = 3;
  localparam int unsigned SRC_PORTS = 3;

  logic                        clk;
  logic                        rst_n;
  logic                        issue_valid;
  logic                        issue_wr;
  logic [REG_AW-1:0]           issue_dst;
  logic                        issue_load;
  logic [SRC_PORTS-1:0]        src_valid;
  logic [SRC_PORTS*REG_AW-1:0] src_reg;
  logic [SRC_PORTS*DATA_W-1:0] src_data;
  logic [STAGES*DATA_W-1:0]    stage_data;
  logic                        pipe_hold;
  logic                        flush;
  logic [SRC_PORTS*DATA_W-1:0] fwd_data;
  logic [SRC_PORTS-1:0]        fwd_hit;
  logic                        stall;
`ifdef FWD_STALL_STATS_EN
  logic [15:0]                 stall_count;
`endif

  fwd_scoreboard #(
    .DATA_W    (DATA_W),
    .REG_AW    (REG_AW),
    .STAGES    (STAGES),
    .SRC_PORTS (SRC_PORTS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_wr    (issue_wr),
    .issue_dst   (issue_dst),
    .issue_load  (issue_load),
    .src_valid   (src_valid),
    .src_reg     (src_reg),
    .src_data    (src_data),
    .stage_data  (stage_data),
    .pipe_hold   (pipe_hold),
    .flush       (flush),
    .fwd_data    (fwd_data),
    .fwd_hit     (fwd_hit),
    .stall       (stall)
`ifdef FWD_STALL_STATS_EN
    ,
    .stall_count (stall_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests;
  int n_fail;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of what each of the last STAGES edges pushed,
  // index 0 = most recent.
  typedef struct {
    bit              v;
    bit [REG_AW-1:0] d;
    bit              ld;
  } wr_t;

  wr_t         hist[$];
  logic [15:0] m_stall_cnt;

  task automatic model_reset();
    wr_t b;
    b.v = 1'b0; b.d = '0; b.ld = 1'b0;
    hist.delete();
    for (int i = 0; i < STAGES; i++) hist.push_back(b);
    m_stall_cnt = '0;
  endtask

  task automatic model_eval(output logic [SRC_PORTS-1:0] e_hit,
                            output logic [SRC_PORTS*DATA_W-1:0] e_data,
                            output logic e_stall);
    e_hit   = '0;
    e_data  = src_data;
    e_stall = 1'b0;
    for (int p = 0; p < SRC_PORTS; p++) begin
      if (src_valid[p] && issue_valid) begin
        for (int i = 0; i < hist.size(); i++) begin
          if (hist[i].v && (hist[i].d == src_reg[p*REG_AW +: REG_AW])) begin
            e_hit[p] = 1'b1;
            e_data[p*DATA_W +: DATA_W] = stage_data[i*DATA_W +: DATA_W];
            if (i == 0 && hist[i].ld) e_stall = 1'b1;
            break;
          end
        end
      end
    end
  endtask

  task automatic model_check();
    logic [SRC_PORTS-1:0]        e_hit;
    logic [SRC_PORTS*DATA_W-1:0] e_data;
    logic                        e_stall;
    model_eval(e_hit, e_data, e_stall);
    chk("hit", 32'(fwd_hit), 32'(e_hit));
    for (int p = 0; p < SRC_PORTS; p++)
      chk($sformatf("data%0d", p), 32'(fwd_data[p*DATA_W +: DATA_W]), 32'(e_data[p*DATA_W +: DATA_W]));
    chk("stall", 32'(stall), 32'(e_stall));
`ifdef FWD_STALL_STATS_EN
    chk("stall_count", 32'(stall_count), 32'(m_stall_cnt));
`endif
  endtask

  task automatic model_update();
    logic [SRC_PORTS-1:0]        e_hit;
    logic [SRC_PORTS*DATA_W-1:0] e_data;
    logic                        e_stall;
    wr_t                         w;
    model_eval(e_hit, e_data, e_stall);
    if (!pipe_hold) begin
      w.v  = issue_valid && issue_wr && !e_stall && !flush;
      w.d  = w.v ? issue_dst : '0;
      w.ld = w.v ? issue_load : 1'b0;
      hist.push_front(w);
      void'(hist.pop_back());
      if (e_stall && !flush && m_stall_cnt != 16'hFFFF) m_stall_cnt = m_stall_cnt + 16'd1;
    end
  endtask

  // Called just after a falling edge with inputs applied.
  task automatic tick();
    #2;
    model_check();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle();
    issue_valid = 1'b0;
    issue_wr    = 1'b0;
    issue_dst   = '0;
    issue_load  = 1'b0;
    src_valid   = '0;
    src_reg     = '0;
    src_data    = {SRC_PORTS{16'(($urandom))}};
    stage_data  = {STAGES{16'(($urandom))}};
    pipe_hold   = 1'b0;
    flush       = 1'b0;
  endtask

  task automatic issue(input logic [REG_AW-1:0] dst, input logic ld);
    issue_valid = 1'b1;
    issue_wr    = 1'b1;
    issue_dst   = dst;
    issue_load  = ld;
  endtask

  task automatic set_src(input int p, input logic [REG_AW-1:0] r, input logic [DATA_W-1:0] d);
    src_valid[p] = 1'b1;
    src_reg[p*REG_AW +: REG_AW] = r;
    src_data[p*DATA_W +: DATA_W] = d;
  endtask

  task automatic set_stage(input int i, input logic [DATA_W-1:0] d);
    stage_data[i*DATA_W +: DATA_W] = d;
  endtask

  task automatic drain();
    idle();
    repeat (STAGES) tick();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    idle();
    model_reset();

    // Reset state: passthrough, no stall.
    @(negedge clk);
    issue_valid = 1'b1;
    set_src(0, 3'd1, 16'h1111);
    #2;
    chk("rst_hit", 32'(fwd_hit), 32'h0);
    chk("rst_stall", 32'(stall), 32'h0);
    chk("rst_data0", 32'(fwd_data[15:0]), 32'h1111);
    @(negedge clk);
    rst_n = 1'b1;
    idle();

    // ALU chain.
    issue(3'd3, 1'b0);
    tick();
    idle();
    issue_valid = 1'b1;
    set_src(0, 3'd3, 16'h0);
    set_stage(0, 16'h1234);
    #2;
    chk("alu_hit0", 32'(fwd_hit[0]), 32'h1);
    chk("alu_data0", 32'(fwd_data[15:0]), 32'h1234);
    chk("alu_stall", 32'(stall), 32'h0);
    tick();

    // Load-use: one stall cycle, then the load value from stage 1.
    drain();
    issue(3'd2, 1'b1);
    tick();
    idle();
    issue(3'd6, 1'b0);
    set_src(1, 3'd2, 16'h0);
    #2;
    chk("lu_stall", 32'(stall), 32'h1);
    chk("lu_hit1", 32'(fwd_hit[1]), 32'h1);
    tick();
    set_stage(1, 16'hBEEF);
    #2;
    chk("lu_stall_gone", 32'(stall), 32'h0);
    chk("lu_data1", 32'(fwd_data[31:16]), 32'hBEEF);
    tick();

    // Double writer: youngest wins.
    drain();
    issue(3'd5, 1'b0);
    tick();
    issue(3'd5, 1'b0);
    tick();
    idle();
    issue_valid = 1'b1;
    set_src(0, 3'd5, 16'h0);
    set_stage(0, 16'h0002);
    set_stage(1, 16'h0001);
    #2;
    chk("dw_data0", 32'(fwd_data[15:0]), 32'h0002);
    tick();

    // pipe_hold keeps a stage-1 match frozen.
    drain();
    issue(3'd1, 1'b0);
    tick();
    idle();
    tick();
    issue_valid = 1'b1;
    pipe_hold   = 1'b1;
    set_src(2, 3'd1, 16'h0);
    set_stage(0, 16'h1111);
    set_stage(1, 16'h5A5A);
    set_stage(2, 16'h7777);
    for (int k = 0; k < 3; k++) begin
      #2;
      chk("hold_hit2", 32'(fwd_hit[2]), 32'h1);
      chk("hold_data2", 32'(fwd_data[47:32]), 32'h5A5A);
      tick();
    end
    pipe_hold = 1'b0;
    #2;
    chk("unhold_data2", 32'(fwd_data[47:32]), 32'h5A5A);
    tick();
    #2;
    chk("adv_data2", 32'(fwd_data[47:32]), 32'h7777);
    tick();

    // Flushed writer never enters the scoreboard.
    drain();
    issue(3'd4, 1'b0);
    flush = 1'b1;
    tick();
    idle();
    issue_valid = 1'b1;
    set_src(0, 3'd4, 16'hCAFE);
    #2;
    chk("flush_hit0", 32'(fwd_hit[0]), 32'h0);
    chk("flush_data0", 32'(fwd_data[15:0]), 32'hCAFE);
    tick();

    // Asynchronous reset mid-stream with three valid entries.
    drain();
    issue(3'd1, 1'b1);
    tick();
    issue(3'd2, 1'b0);
    tick();
    issue(3'd3, 1'b0);
    tick();
    idle();
    issue_valid = 1'b1;
    set_src(0, 3'd1, 16'hA001);
    set_src(1, 3'd2, 16'hA002);
    set_src(2, 3'd3, 16'hA003);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mrst_hit", 32'(fwd_hit), 32'h0);
    chk("mrst_stall", 32'(stall), 32'h0);
    chk("mrst_data", 32'(fwd_data[47:32]), 32'hA003);
    chk("mrst_data0", 32'(fwd_data[15:0]), 32'hA001);
`ifdef FWD_STALL_STATS_EN
    chk("mrst_count", 32'(stall_count), 32'h0);
`endif
    model_reset();
    #1;
    rst_n = 1'b1;
    issue_valid = 1'b0;
    @(posedge clk);
    model_update();
    @(negedge clk);

    // Random traffic against the model.
    for (int c = 0; c < 800; c++) begin
      idle();
      issue_valid = ($urandom_range(0, 9) < 8);
      issue_wr    = ($urandom_range(0, 9) < 7);
      issue_dst   = ($urandom_range(0, 3) == 0) ? REG_AW'($urandom) : REG_AW'($urandom_range(0, 3));
      issue_load  = ($urandom_range(0, 9) < 3);
      pipe_hold   = ($urandom_range(0, 9) == 0);
      flush       = ($urandom_range(0, 19) == 0);
      for (int p = 0; p < SRC_PORTS; p++) begin
        src_valid[p] = ($urandom_range(0, 3) != 0);
        src_reg[p*REG_AW +: REG_AW] = REG_AW'($urandom_range(0, 3));
        src_data[p*DATA_W +: DATA_W] = DATA_W'($urandom);
      end
      for (int i = 0; i < STAGES; i++) set_stage(i, DATA_W'($urandom));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
